// File: rtl/seq_mul_add8_if.sv
// Handshake and data bundle for seq_mul_add8: operand triple in, product out.
// The slave modport is the multiplier side, master is the producer/consumer side.
interface seq_mul_add8_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rop;
  logic [WIDTH-1:0]   mod;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   lop;
  logic               ovf;
  logic               mod_err;

  modport slave (
    input  in_valid, quot, rop, mod, out_ready,
    output in_ready, out_valid, prod, lop, ovf, mod_err
  );

  modport master (
    output in_valid, quot, rop, mod, out_ready,
    input  in_ready, out_valid, prod, lop, ovf, mod_err
  );
endinterface

// File: rtl/seq_mul_add8.sv
// Iterative shift-add unit: prod = quot * rop + mod, one multiplier bit per cycle.
// Optional remainder consistency flag enabled by defining SEQ_MUL_ADD_CHECK_EN.
module seq_mul_add8 #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  seq_mul_add8_if.slave     bus,
  output logic [1:0]        o_state
);
  // Handshake: a transfer happens on an edge where valid and ready are both 1;
  // valid never waits on ready, and operands/results stay stable until transfer.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplr;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_prod;
  logic [2*WIDTH-1:0]   w_acc_next;
  logic                 w_last;

  assign w_acc_next = r_acc + (r_mplr[0] ? r_mcand : '0);
  assign w_last     = (r_cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.in_valid)  w_next = S_BUSY;
      S_BUSY:  if (w_last)        w_next = S_DONE;
      S_DONE:  if (bus.out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc   <= '0;
      r_mcand <= '0;
      r_mplr  <= '0;
      r_cnt   <= '0;
      r_prod  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.in_valid) begin
          r_acc   <= {{WIDTH{1'b0}}, bus.mod};
          r_mcand <= {{WIDTH{1'b0}}, bus.rop};
          r_mplr  <= bus.quot;
          r_cnt   <= '0;
        end
        S_BUSY: begin
          r_acc   <= w_acc_next;
          r_mcand <= r_mcand << 1;
          r_mplr  <= r_mplr >> 1;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) r_prod <= w_acc_next;
        end
        default: ;
      endcase
    end
  end

`ifdef SEQ_MUL_ADD_CHECK_EN
  // A valid divide always yields rop != 0 and mod < rop.
  logic r_chk;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              r_chk <= 1'b0;
    else if (r_state == S_IDLE && bus.in_valid)
      r_chk <= (bus.rop == '0) || (bus.mod >= bus.rop);
  end
  assign bus.mod_err = (r_state == S_DONE) && r_chk;
`else
  assign bus.mod_err = 1'b0;
`endif

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.prod      = r_prod;
  assign bus.lop       = r_prod[WIDTH-1:0];
  assign bus.ovf       = |r_prod[2*WIDTH-1:WIDTH];
  assign o_state       = r_state;
endmodule
